ardisik_bolucu: RTL and testbench

ARDISIK_BOLUCU -- requirements
Module: ardisik_bolucu

---
 rtl/ardisik_bolucu_if.sv | 27 ++
 rtl/ardisik_bolucu.sv | 156 +++++++++++++++
 tb/tb_ardisik_bolucu.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ardisik_bolucu_if.sv
// Start/result bundle for the sequential fixed-point divider with BCD output.
interface ardisik_bolucu_if #(
   parameter int unsigned TAM_W     = 8,
   parameter int unsigned KESIR_W   = 2,
   parameter int unsigned BOLEN_W   = 6,
   parameter int unsigned ONDALIK_N = 2,
   parameter int unsigned TAM_BCD_N = 3
);
   logic                                 basla;
   logic [TAM_W+KESIR_W-1:0]             bolunen;
   logic [BOLEN_W-1:0]                   bolen;
   logic                                 mesgul;
   logic                                 hazir;
   logic                                 hata;
   logic                                 tasma;
   logic [4*(TAM_BCD_N+ONDALIK_N)-1:0]   sonuc_bcd;

   modport master (
      output basla, bolunen, bolen,
      input  mesgul, hazir, hata, tasma, sonuc_bcd
   );

   modport slave (
      input  basla, bolunen, bolen,
      output mesgul, hazir, hata, tasma, sonuc_bcd
   );
endinterface

// File: rtl/ardisik_bolucu.sv
// Sequential divider: restoring division then shift-add-3 BCD conversion, one bit per clock.
// Optional overflow saturation enabled by defining ARDISIK_BOLUCU_TASMA_KONTROL_EN.
module ardisik_bolucu #(
   parameter int unsigned TAM_W     = 8,
   parameter int unsigned KESIR_W   = 2,
   parameter int unsigned BOLEN_W   = 6,
   parameter int unsigned ONDALIK_N = 2,
   parameter int unsigned TAM_BCD_N = 3
) (
   input logic              clk,
   input logic              rst,
   ardisik_bolucu_if.slave  bus
);
   localparam int unsigned GW = TAM_W + KESIR_W;
   localparam int unsigned NW = GW + $clog2(10**ONDALIK_N);
   localparam int unsigned DW = BOLEN_W + KESIR_W;
   localparam int unsigned BN = TAM_BCD_N + ONDALIK_N;
   localparam int unsigned BW = 4 * BN;
   localparam int unsigned CW = $clog2(NW);

   localparam logic [NW-1:0] ON_CARPAN = NW'(10**ONDALIK_N);
   localparam logic [CW-1:0] SON_ADIM  = CW'(NW - 1);

   localparam logic [1:0] BOSTA = 2'd0;
   localparam logic [1:0] BOL   = 2'd1;
   localparam logic [1:0] BCD   = 2'd2;
   localparam logic [1:0] BITTI = 2'd3;

   logic [1:0]    durum_q;
   logic [CW-1:0] sayac_q;
   logic [NW-1:0] bolum_q;
   logic [DW-1:0] kalan_q;
   logic [DW-1:0] payda_q;
   logic [BW-1:0] bcd_q;
   logic          sifir_q;
   logic          mesgul_q;
   logic          hazir_q;
   logic          hata_q;
   logic [BW-1:0] sonuc_q;

   logic [DW:0]   kaydir;
   logic          bol_bit;
   logic [DW-1:0] kalan_sonraki;
   logic [NW-1:0] bolum_sonraki;
   logic [BW-1:0] bcd_ayar;

`ifdef ARDISIK_BOLUCU_TASMA_KONTROL_EN
   localparam logic [63:0]   SINIR    = 64'(10**BN);
   localparam logic [BW-1:0] DOKUZLAR = {BN{4'h9}};
   logic tasma_ic_q;
   logic tasma_q;
`endif

   // Numerator bits stream out of bolum_q's MSB while quotient bits enter at its LSB.
   always_comb begin
      kaydir        = {kalan_q, bolum_q[NW-1]};
      bol_bit       = (kaydir >= {1'b0, payda_q});
      kalan_sonraki = bol_bit ? DW'(kaydir - {1'b0, payda_q}) : kaydir[DW-1:0];
      bolum_sonraki = {bolum_q[NW-2:0], bol_bit};
   end

   always_comb begin
      bcd_ayar = bcd_q;
      for (int i = 0; i < int'(BN); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_ayar[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         durum_q    <= BOSTA;
         sayac_q    <= '0;
         bolum_q    <= '0;
         kalan_q    <= '0;
         payda_q    <= '0;
         bcd_q      <= '0;
         sifir_q    <= 1'b0;
         mesgul_q   <= 1'b0;
         hazir_q    <= 1'b0;
         hata_q     <= 1'b0;
         sonuc_q    <= '0;
`ifdef ARDISIK_BOLUCU_TASMA_KONTROL_EN
         tasma_ic_q <= 1'b0;
         tasma_q    <= 1'b0;
`endif
      end else begin
         hazir_q <= 1'b0;
         case (durum_q)
            BOSTA: begin
               if (bus.basla) begin
                  bolum_q    <= NW'(bus.bolunen) * ON_CARPAN;
                  payda_q    <= {bus.bolen, {KESIR_W{1'b0}}};
                  kalan_q    <= '0;
                  bcd_q      <= '0;
                  sayac_q    <= '0;
                  sifir_q    <= (bus.bolen == '0);
                  mesgul_q   <= 1'b1;
`ifdef ARDISIK_BOLUCU_TASMA_KONTROL_EN
                  tasma_ic_q <= 1'b0;
`endif
                  // A zero divisor goes straight to the result cycle.
                  durum_q    <= (bus.bolen == '0) ? BITTI : BOL;
               end
            end
            BOL: begin
               bolum_q <= bolum_sonraki;
               kalan_q <= kalan_sonraki;
               if (sayac_q == SON_ADIM) begin
                  sayac_q <= '0;
                  durum_q <= BCD;
`ifdef ARDISIK_BOLUCU_TASMA_KONTROL_EN
                  tasma_ic_q <= (64'(bolum_sonraki) >= SINIR);
`endif
               end else begin
                  sayac_q <= sayac_q + CW'(1);
               end
            end
            BCD: begin
               bcd_q   <= BW'({bcd_ayar, bolum_q[NW-1]});
               bolum_q <= {bolum_q[NW-2:0], 1'b0};
               if (sayac_q == SON_ADIM) begin
                  sayac_q <= '0;
                  durum_q <= BITTI;
               end else begin
                  sayac_q <= sayac_q + CW'(1);
               end
            end
            BITTI: begin
               hata_q   <= sifir_q;
`ifdef ARDISIK_BOLUCU_TASMA_KONTROL_EN
               tasma_q  <= tasma_ic_q;
               sonuc_q  <= sifir_q ? '0 : (tasma_ic_q ? DOKUZLAR : bcd_q);
`else
               sonuc_q  <= sifir_q ? '0 : bcd_q;
`endif
               hazir_q  <= 1'b1;
               mesgul_q <= 1'b0;
               durum_q  <= BOSTA;
            end
            default: durum_q <= BOSTA;
         endcase
      end
   end

   assign bus.mesgul    = mesgul_q;
   assign bus.hazir     = hazir_q;
   assign bus.hata      = hata_q;
   assign bus.sonuc_bcd = sonuc_q;
`ifdef ARDISIK_BOLUCU_TASMA_KONTROL_EN
   assign bus.tasma     = tasma_q;
`else
   assign bus.tasma     = 1'b0;
`endif
endmodule

// File: tb/tb_ardisik_bolucu.sv
// Bench for ardisik_bolucu: arithmetic reference model checked every cycle plus directed literals.
module tb_ardisik_bolucu;
   localparam int NW  = 10 + $clog2(100);
   localparam int LAT = 2 * NW + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       basla = 1'b0;
   logic [9:0] bolunen = '0;
   logic [5:0] bolen = '0;
   bit         chk_en = 1'b0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   ardisik_bolucu_if #(.TAM_BCD_N(3)) bus0 ();
   ardisik_bolucu_if #(.TAM_BCD_N(1)) bus1 ();

   assign bus0.basla   = basla;
   assign bus0.bolunen = bolunen;
   assign bus0.bolen   = bolen;
   assign bus1.basla   = basla;
   assign bus1.bolunen = bolunen;
   assign bus1.bolen   = bolen;

   ardisik_bolucu #(.TAM_BCD_N(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   ardisik_bolucu #(.TAM_BCD_N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] bcd_of(input int unsigned v, input int nd);
      logic [31:0] r = '0;
      int unsigned p = 1;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic sonuc_for(input int unsigned q, input int nd,
                            output logic [31:0] s, output bit t);
      int unsigned lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
`ifdef ARDISIK_BOLUCU_TASMA_KONTROL_EN
      if (q >= lim) begin
         t = 1'b1;
         s = bcd_of(lim - 1, nd);
      end else begin
         t = 1'b0;
         s = bcd_of(q, nd);
      end
`else
      t = 1'b0;
      s = bcd_of(q % lim, nd);
`endif
   endtask

   // Reference model: timing from accept edge, value from q = floor(b*100 / (d*4)).
   int unsigned ecount = 0;
   int unsigned done_e = 0;
   bit          pend = 1'b0;
   bit          m_hazir = 1'b0, m_mesgul = 1'b0, m_hata = 1'b0;
   bit          m_tasma0 = 1'b0, m_tasma1 = 1'b0;
   logic [31:0] m_sonuc0 = '0, m_sonuc1 = '0;
   bit          p_hata = 1'b0, p_tasma0 = 1'b0, p_tasma1 = 1'b0;
   logic [31:0] p_sonuc0 = '0, p_sonuc1 = '0;

   initial begin
      int unsigned q;
      forever begin
         @(posedge clk);
         ecount++;
         m_hazir = 1'b0;
         if (rst) begin
            pend = 1'b0; m_mesgul = 1'b0; m_hata = 1'b0;
            m_tasma0 = 1'b0; m_tasma1 = 1'b0; m_sonuc0 = '0; m_sonuc1 = '0;
         end else if (pend && ecount == done_e) begin
            pend = 1'b0; m_hazir = 1'b1; m_mesgul = 1'b0; m_hata = p_hata;
            m_tasma0 = p_tasma0; m_tasma1 = p_tasma1;
            m_sonuc0 = p_sonuc0; m_sonuc1 = p_sonuc1;
         end else if (!pend && basla) begin
            pend = 1'b1; m_mesgul = 1'b1;
            if (bolen == 0) begin
               done_e = ecount + 1;
               p_hata = 1'b1; p_tasma0 = 1'b0; p_tasma1 = 1'b0;
               p_sonuc0 = '0; p_sonuc1 = '0;
            end else begin
               done_e = ecount + LAT;
               q = (int'(bolunen) * 100) / (int'(bolen) * 4);
               p_hata = 1'b0;
               sonuc_for(q, 5, p_sonuc0, p_tasma0);
               sonuc_for(q, 3, p_sonuc1, p_tasma1);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("hazir0", bus0.hazir, m_hazir);
            chk("mesgul0", bus0.mesgul, m_mesgul);
            chk("hata0", bus0.hata, m_hata);
            chk("tasma0", bus0.tasma, m_tasma0);
            chk("sonuc0", bus0.sonuc_bcd, m_sonuc0);
            chk("hazir1", bus1.hazir, m_hazir);
            chk("hata1", bus1.hata, m_hata);
            chk("tasma1", bus1.tasma, m_tasma1);
            chk("sonuc1", bus1.sonuc_bcd, m_sonuc1);
         end
      end
   end

   // Called at a negedge; leaves the bench at the negedge where hazir is seen.
   task automatic run(input int unsigned b, input int unsigned d, input logic [19:0] exp0,
                      input int exp_lat, input bit exp_hata, input bit inj);
      int n = 0;
      bolunen = 10'(b);
      bolen   = 6'(d);
      basla   = 1'b1;
      @(negedge clk);
      basla = 1'b0;
      while (!bus0.hazir && n < LAT + 10) begin
         @(negedge clk);
         n++;
         if (inj && (n == 4 || n == 19)) begin
            basla   = 1'b1;
            bolunen = 10'd1000;
            bolen   = 6'd7;
         end else begin
            basla = 1'b0;
         end
      end
      chk("latency", n, exp_lat);
      chk("sonuc_lit", bus0.sonuc_bcd, exp0);
      chk("hata_lit", bus0.hata, exp_hata);
      chk("model_lit", m_sonuc0, exp0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_hazir", bus0.hazir, 0);
      chk("rst_mesgul", bus0.mesgul, 0);
      chk("rst_sonuc", bus0.sonuc_bcd, 0);
      rst = 1'b0;
      @(negedge clk);

      run(25, 3, 20'h00208, LAT, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      // Back-to-back: each start is raised in the hazir cycle of the previous one.
      run(240, 4, 20'h01500, LAT, 1'b0, 1'b0);
`ifdef ARDISIK_BOLUCU_TASMA_KONTROL_EN
      chk("sonuc1_lit", bus1.sonuc_bcd, 12'h999);
      chk("tasma1_lit", bus1.tasma, 1);
`else
      chk("sonuc1_lit", bus1.sonuc_bcd, 12'h500);
      chk("tasma1_lit", bus1.tasma, 0);
`endif
      run(352, 8, 20'h01100, LAT, 1'b0, 1'b0);
      run(50, 5, 20'h00250, LAT, 1'b0, 1'b0);
      run(82, 2, 20'h01025, LAT, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      run(400, 0, 20'h00000, 1, 1'b1, 1'b0);
      run(25, 3, 20'h00208, LAT, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      run(25, 3, 20'h00208, LAT, 1'b0, 1'b1);
      repeat (2) @(negedge clk);

      // Abort mid-operation; reset also wins over a simultaneous start.
      bolunen = 10'd25; bolen = 6'd3; basla = 1'b1;
      @(negedge clk);
      basla = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1; basla = 1'b1;
      @(negedge clk);
      chk("abort_hazir", bus0.hazir, 0);
      chk("abort_mesgul", bus0.mesgul, 0);
      chk("abort_sonuc", bus0.sonuc_bcd, 0);
      rst = 1'b0;
      run(25, 3, 20'h00208, LAT, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
